// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory read bus between fetch unit and memory
interface pc_fetch_unit_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_waitrequest,
    input  imem_readdata
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_waitrequest,
    output imem_readdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC and fetch/issue sequencer with branch-delay-slot handling
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  input  logic                   stall,
  output logic                   active
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        delay_pending, delay_pending_d;
  logic [31:0] delay_target, delay_target_d;
  logic [31:0] npc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FETCH;
      pc            <= RESET_VECTOR;
      instr         <= 32'h0;
      delay_pending <= 1'b0;
      delay_target  <= 32'h0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      instr         <= instr_d;
      delay_pending <= delay_pending_d;
      delay_target  <= delay_target_d;
    end
  end

  // A pending delay-slot target overrides sequential flow exactly once.
  assign npc = delay_pending ? delay_target : (pc + 32'd4);

  always_comb begin
    state_d         = state;
    pc_d            = pc;
    instr_d         = instr;
    delay_pending_d = delay_pending;
    delay_target_d  = delay_target;
    case (state)
      FETCH: begin
        if (!imem.imem_waitrequest) begin
          instr_d = imem.imem_readdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          pc_d = npc;
          // A branch sitting in a delay slot loses to the earlier branch.
          if (delay_pending) begin
            delay_pending_d = 1'b0;
          end else if (redirect) begin
            delay_pending_d = 1'b1;
            delay_target_d  = redirect_target & ~32'h3;
          end
          state_d = (npc == HALT_ADDR) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem.imem_address = pc;
  assign imem.imem_read    = (state == FETCH) && rst_n;
  assign instr_valid       = (state == ISSUE);
  assign active            = (state != HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - table-driven directed bench for pc_fetch_unit
module tb_pc_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [31:0] rd;
    logic        st;
    logic        rdr;
    logic [31:0] tgt;
    logic        e_read;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_active;
    logic [31:0] e_instr;
  } vec_t;

  localparam logic [31:0] D = 32'hDEADBEEF;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        active;

  int checks;
  int errors;

  vec_t tbl[$];

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_VECTOR(32'hBFC00000),
    .HALT_ADDR   (32'h00000000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .pc             (pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .stall          (stall),
    .active         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input int k);
    return 32'h24000000 + 32'(k);
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] d,
                              input logic s, input logic b, input logic [31:0] t,
                              input logic er, input logic [31:0] ep, input logic ev,
                              input logic ea, input logic [31:0] ei);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = d; v.st = s; v.rdr = b; v.tgt = t;
    v.e_read = er; v.e_pc = ep; v.e_valid = ev; v.e_active = ea; v.e_instr = ei;
    return v;
  endfunction

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    stall = 1'b0;
    bus.imem_waitrequest = 1'b0;
    bus.imem_readdata = 32'h0;

    // reset state
    tbl.push_back(mk(0,0,D,0,0,0,              0,32'hBFC00000,0,1,32'h0));
    // sequential fetch, 3-cycle wait on BFC00004
    tbl.push_back(mk(1,0,ins(0),0,0,0,         1,32'hBFC00000,0,1,32'h0));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00000,1,1,ins(0)));
    tbl.push_back(mk(1,1,D,0,0,0,              1,32'hBFC00004,0,1,ins(0)));
    tbl.push_back(mk(1,1,D,0,0,0,              1,32'hBFC00004,0,1,ins(0)));
    tbl.push_back(mk(1,1,D,0,0,0,              1,32'hBFC00004,0,1,ins(0)));
    tbl.push_back(mk(1,0,ins(1),0,0,0,         1,32'hBFC00004,0,1,ins(0)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00004,1,1,ins(1)));
    tbl.push_back(mk(1,0,ins(2),0,0,0,         1,32'hBFC00008,0,1,ins(1)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00008,1,1,ins(2)));
    tbl.push_back(mk(1,0,ins(3),0,0,0,         1,32'hBFC0000C,0,1,ins(2)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC0000C,1,1,ins(3)));
    tbl.push_back(mk(1,0,ins(4),0,0,0,         1,32'hBFC00010,0,1,ins(3)));
    // branch at BFC00010 to BFC00103 (low bits dropped)
    tbl.push_back(mk(1,0,D,0,1,32'hBFC00103,   0,32'hBFC00010,1,1,ins(4)));
    tbl.push_back(mk(1,0,ins(5),0,0,0,         1,32'hBFC00014,0,1,ins(4)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00014,1,1,ins(5)));
    tbl.push_back(mk(1,0,ins(6),0,0,0,         1,32'hBFC00100,0,1,ins(5)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00100,1,1,ins(6)));
    tbl.push_back(mk(1,0,ins(7),0,0,0,         1,32'hBFC00104,0,1,ins(6)));
    // stall 5 cycles with redirect toggling, commit-cycle redirect taken
    tbl.push_back(mk(1,0,D,1,1,32'hBFC00300,   0,32'hBFC00104,1,1,ins(7)));
    tbl.push_back(mk(1,0,D,1,0,0,              0,32'hBFC00104,1,1,ins(7)));
    tbl.push_back(mk(1,0,D,1,1,32'hBFC00400,   0,32'hBFC00104,1,1,ins(7)));
    tbl.push_back(mk(1,0,D,1,0,0,              0,32'hBFC00104,1,1,ins(7)));
    tbl.push_back(mk(1,0,D,1,1,32'hBFC00500,   0,32'hBFC00104,1,1,ins(7)));
    tbl.push_back(mk(1,0,D,0,1,32'hBFC00200,   0,32'hBFC00104,1,1,ins(7)));
    tbl.push_back(mk(1,0,ins(8),0,0,0,         1,32'hBFC00108,0,1,ins(7)));
    // branch in delay slot is ignored
    tbl.push_back(mk(1,0,D,0,1,32'hBFC00600,   0,32'hBFC00108,1,1,ins(8)));
    tbl.push_back(mk(1,0,ins(9),0,0,0,         1,32'hBFC00200,0,1,ins(8)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00200,1,1,ins(9)));
    tbl.push_back(mk(1,0,ins(10),0,0,0,        1,32'hBFC00204,0,1,ins(9)));
    // jump to HALT_ADDR: delay slot runs, then halt
    tbl.push_back(mk(1,0,D,0,1,32'h00000000,   0,32'hBFC00204,1,1,ins(10)));
    tbl.push_back(mk(1,0,ins(11),0,0,0,        1,32'hBFC00208,0,1,ins(10)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00208,1,1,ins(11)));
    tbl.push_back(mk(1,0,D,0,1,32'hBFC00000,   0,32'h00000000,0,0,ins(11)));
    tbl.push_back(mk(1,0,D,1,0,0,              0,32'h00000000,0,0,ins(11)));
    tbl.push_back(mk(1,1,D,0,1,32'hBFC00040,   0,32'h00000000,0,0,ins(11)));
    // reset out of HALTED
    tbl.push_back(mk(0,0,D,0,0,0,              0,32'h00000000,0,0,ins(11)));
    tbl.push_back(mk(1,0,ins(12),0,0,0,        1,32'hBFC00000,0,1,32'h0));
    tbl.push_back(mk(1,0,D,0,1,32'hBFC00800,   0,32'hBFC00000,1,1,ins(12)));
    // reset mid-fetch with waitrequest high and a delay target pending
    tbl.push_back(mk(1,1,D,0,0,0,              1,32'hBFC00004,0,1,ins(12)));
    tbl.push_back(mk(0,1,ins(13),0,0,0,        0,32'hBFC00004,0,1,ins(12)));
    tbl.push_back(mk(0,0,ins(13),0,0,0,        0,32'hBFC00000,0,1,32'h0));
    tbl.push_back(mk(1,0,ins(14),0,0,0,        1,32'hBFC00000,0,1,32'h0));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00000,1,1,ins(14)));
    tbl.push_back(mk(1,0,ins(15),0,0,0,        1,32'hBFC00004,0,1,ins(14)));
    // jump to FFFFFFFC: pc+4 wraps to HALT_ADDR
    tbl.push_back(mk(1,0,D,0,1,32'hFFFFFFFF,   0,32'hBFC00004,1,1,ins(15)));
    tbl.push_back(mk(1,0,ins(16),0,0,0,        1,32'hBFC00008,0,1,ins(15)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hBFC00008,1,1,ins(16)));
    tbl.push_back(mk(1,0,ins(17),0,0,0,        1,32'hFFFFFFFC,0,1,ins(16)));
    tbl.push_back(mk(1,0,D,0,0,0,              0,32'hFFFFFFFC,1,1,ins(17)));
    tbl.push_back(mk(1,0,D,0,1,32'hBFC00000,   0,32'h00000000,0,0,ins(17)));

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n                = tbl[i].rst_n;
      bus.imem_waitrequest = tbl[i].wr;
      bus.imem_readdata    = tbl[i].rd;
      stall                = tbl[i].st;
      redirect             = tbl[i].rdr;
      redirect_target      = tbl[i].tgt;
      #1;
      chk(i, "imem_read",    32'(bus.imem_read),  32'(tbl[i].e_read));
      chk(i, "imem_address", bus.imem_address,    tbl[i].e_pc);
      chk(i, "pc",           pc,                  tbl[i].e_pc);
      chk(i, "instr_valid",  32'(instr_valid),    32'(tbl[i].e_valid));
      chk(i, "active",       32'(active),         32'(tbl[i].e_active));
      chk(i, "instr",        instr,               tbl[i].e_instr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
